// File: rtl/cfi_shadow_stack_ctrl_pkg.sv
// Purpose: shared constants and types for the commit-time shadow stack / CFI key manager.
//   CFI_KEY_RST  : XOR key value after reset, also used by the branch unit.
//   cfi_commit_t : call/return commit payload driven by the commit stage.
//   cfi_key_state_e : key manager FSM states.
package cfi_shadow_stack_ctrl_pkg;

  localparam int unsigned CFI_VLEN  = 32;
  localparam int unsigned CFI_KEY_W = 31;

  localparam logic [CFI_KEY_W-1:0] CFI_KEY_RST = 31'h73fa06c2;

  typedef struct packed {
    logic                call_valid;
    logic [CFI_VLEN-1:0] call_ret_addr;
    logic                ret_valid;
    logic [CFI_VLEN-1:0] ret_target;
  } cfi_commit_t;

  typedef enum logic {
    KS_RUN  = 1'b0,
    KS_PEND = 1'b1
  } cfi_key_state_e;

endpackage

// File: rtl/cfi_ras_mem.sv
// Purpose: DEPTH x VLEN return-address register file, one write port and one
//   combinational read port. Contents are not reset; validity is tracked by the
//   entry count in the controller.
// Ports:
//   clk_i    clock
//   we_i     write enable
//   waddr_i  write index
//   wdata_i  write data
//   raddr_i  read index (top of stack)
//   rdata_o  combinational read data
module cfi_ras_mem #(
  parameter  int unsigned VLEN  = 32,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  logic [VLEN-1:0]  wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output logic [VLEN-1:0]  rdata_o
);

  logic [VLEN-1:0] r_mem [DEPTH];

  // Write port
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      r_mem[waddr_i] <= wdata_i;
    end
  end

  // Combinational top-of-stack read
  assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/cfi_shadow_stack_ctrl.sv
// Purpose: commit-time return-address guard and XOR key manager. Pushes the plain
//   return address on each committed call, pops and compares on each committed
//   return, and defers key changes until the shadow stack is empty.
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   debug_mode_i         gates push/pop (key load and alarm clear still work)
//   call_valid_i / call_ret_addr_i   committed call and its return address
//   ret_valid_i / ret_target_i       committed return and its target
//   key_we_i / key_wdata_i           key load request
//   alarm_clr_i          clears the sticky alarm
//   key_o, key_pending_o active key, key write waiting for an empty stack
//   violation_o, alarm_o one-cycle mismatch pulse, sticky mismatch flag
//   overflow_o, depth_o  sticky overwrite flag, live entry count
module cfi_shadow_stack_ctrl
  import cfi_shadow_stack_ctrl_pkg::*;
#(
  parameter int unsigned            VLEN    = CFI_VLEN,
  parameter int unsigned            DEPTH   = 16,
  parameter logic [CFI_KEY_W-1:0]   KEY_RST = CFI_KEY_RST
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       debug_mode_i,
  input  logic                       call_valid_i,
  input  logic [VLEN-1:0]            call_ret_addr_i,
  input  logic                       ret_valid_i,
  input  logic [VLEN-1:0]            ret_target_i,
  input  logic                       key_we_i,
  input  logic [CFI_KEY_W-1:0]       key_wdata_i,
  input  logic                       alarm_clr_i,
  output logic [CFI_KEY_W-1:0]       key_o,
  output logic                       key_pending_o,
  output logic                       violation_o,
  output logic                       alarm_o,
  output logic                       overflow_o,
  output logic [$clog2(DEPTH):0]     depth_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0]     r_ptr;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_violation;
  logic                 r_alarm;
  logic                 r_overflow;
  cfi_key_state_e       r_state;
  logic [CFI_KEY_W-1:0] r_key;
  logic [CFI_KEY_W-1:0] r_pend_data;
  logic                 r_key_pend;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_mismatch;
  logic                 w_viol_evt;
  logic                 w_ovf_evt;
  logic [VLEN-1:0]      w_top;
  logic [PTR_W-1:0]     w_ptr_pop;
  logic [PTR_W-1:0]     w_ptr_nxt;
  logic [CNT_W-1:0]     w_cnt_pop;
  logic [CNT_W-1:0]     w_cnt_nxt;

  // Stack bookkeeping: the pop is applied first, then the push on top of it,
  // so a same-cycle call+return compares the old top and replaces it.
  always_comb begin
    w_push     = call_valid_i & ~debug_mode_i;
    w_pop      = ret_valid_i & ~debug_mode_i & (r_cnt != '0);
    // bit 0 is masked out of the compare
    w_mismatch = ((w_top ^ ret_target_i) & ~VLEN'(1)) != '0;
    w_viol_evt = w_pop & w_mismatch;
    w_ptr_pop  = w_pop ? r_ptr - PTR_W'(1) : r_ptr;
    w_cnt_pop  = w_pop ? r_cnt - CNT_W'(1) : r_cnt;
    w_ptr_nxt  = w_push ? w_ptr_pop + PTR_W'(1) : w_ptr_pop;
    w_ovf_evt  = w_push & (w_cnt_pop == CNT_FULL);
    w_cnt_nxt  = (w_push & ~w_ovf_evt) ? w_cnt_pop + CNT_W'(1) : w_cnt_pop;
  end

  cfi_ras_mem #(
    .VLEN  (VLEN),
    .DEPTH (DEPTH)
  ) u_ras_mem (
    .clk_i   (clk_i),
    .we_i    (w_push),
    .waddr_i (w_ptr_nxt),
    .wdata_i (call_ret_addr_i),
    .raddr_i (r_ptr),
    .rdata_o (w_top)
  );

  // Pointers, count and check flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_violation <= 1'b0;
      r_alarm     <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_ptr       <= w_ptr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_violation <= w_viol_evt;
      r_alarm     <= w_viol_evt | (r_alarm & ~alarm_clr_i);
      r_overflow  <= r_overflow | w_ovf_evt;
    end
  end

  // Key manager FSM: a new key only takes effect while no obfuscated
  // return address can be live, i.e. the stack stays empty across the edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= KS_RUN;
      r_key       <= KEY_RST;
      r_pend_data <= '0;
      r_key_pend  <= 1'b0;
    end else begin
      case (r_state)
        KS_RUN: begin
          if (key_we_i) begin
            if ((r_cnt == '0) && !w_push) begin
              r_key <= key_wdata_i;
            end else begin
              r_pend_data <= key_wdata_i;
              r_key_pend  <= 1'b1;
              r_state     <= KS_PEND;
            end
          end
        end
        KS_PEND: begin
          if ((w_cnt_nxt == '0) && !w_push) begin
            r_key      <= key_we_i ? key_wdata_i : r_pend_data;
            r_key_pend <= 1'b0;
            r_state    <= KS_RUN;
          end else if (key_we_i) begin
            r_pend_data <= key_wdata_i;
          end
        end
        default: begin
          r_state <= KS_RUN;
        end
      endcase
    end
  end

  assign key_o         = r_key;
  assign key_pending_o = r_key_pend;
  assign violation_o   = r_violation;
  assign alarm_o       = r_alarm;
  assign overflow_o    = r_overflow;
  assign depth_o       = r_cnt;

endmodule
